line_buffer_param: RTL and testbench

- Parametrised successor to the single-line, 8-bit, 512-deep line buffer in the spatial-filter datapath.
- Circular store of one image line with generic pixel width, line length (any integer, not only power of two) and kernel width.
- Occupancy tracking with full/empty flags and ready/valid handshakes, so the upstream pixel source and downstream kernel/MAC stage cannot over- or under-run it.
- Registered window output: KERNEL_W consecutive pixels per read.

---
 rtl/line_buffer_param_if.sv | 54 +++++
 rtl/line_buffer_param.sv | 133 +++++++++++++
 tb/tb_line_buffer_param.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/line_buffer_param_if.sv
// Bus bundle for line_buffer_param: pixel write side, window read side, and status.
// LINEBUF_ERR_STATS_EN adds the sticky overflow/underflow flags and the drop counter.
interface line_buffer_param_if #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int KERNEL_W = 3
);
  localparam int CW = $clog2(LINE_LEN + 1);

  // Handshake semantics: a write is accepted on a rising edge where
  // i_data_valid && o_wr_ready; a read is accepted where i_rd_data && o_rd_ready.
  // Both ready signals reflect the state before that edge, so a request
  // may be held high while ready is low without side effects on the store.
  logic [DATA_W-1:0]          i_data;
  logic                       i_data_valid;
  logic                       o_wr_ready;
  logic                       i_rd_data;
  logic                       o_rd_ready;
  logic [KERNEL_W*DATA_W-1:0] o_data;
  logic                       o_data_valid;
  logic [CW-1:0]              o_count;
  logic                       o_full;
  logic                       o_empty;
  logic                       o_line_end;
`ifdef LINEBUF_ERR_STATS_EN
  logic                       o_ovf;
  logic                       o_udf;
  logic [15:0]                o_drop_cnt;
`endif

`ifdef LINEBUF_ERR_STATS_EN
  modport slave (
    input  i_data, i_data_valid, i_rd_data,
    output o_wr_ready, o_rd_ready, o_data, o_data_valid, o_count,
           o_full, o_empty, o_line_end, o_ovf, o_udf, o_drop_cnt
  );
  modport master (
    output i_data, i_data_valid, i_rd_data,
    input  o_wr_ready, o_rd_ready, o_data, o_data_valid, o_count,
           o_full, o_empty, o_line_end, o_ovf, o_udf, o_drop_cnt
  );
`else
  modport slave (
    input  i_data, i_data_valid, i_rd_data,
    output o_wr_ready, o_rd_ready, o_data, o_data_valid, o_count,
           o_full, o_empty, o_line_end
  );
  modport master (
    output i_data, i_data_valid, i_rd_data,
    input  o_wr_ready, o_rd_ready, o_data, o_data_valid, o_count,
           o_full, o_empty, o_line_end
  );
`endif
endinterface

// File: rtl/line_buffer_param.sv
// Circular single-line pixel store with occupancy tracking and a registered KERNEL_W-wide window.
// Optional error statistics (o_ovf, o_udf, o_drop_cnt) are enabled by LINEBUF_ERR_STATS_EN.
module line_buffer_param #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int KERNEL_W = 3
) (
  input logic               i_clk,
  input logic               i_rst,
  line_buffer_param_if.slave bus
);
  // A one-entry line still needs a one-bit pointer.
  localparam int PW  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(LINE_LEN + 1);
  localparam int WW  = KERNEL_W * DATA_W;

  localparam logic [PW-1:0]  PTR_LAST = PW'(LINE_LEN - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(LINE_LEN);
  localparam logic [CW-1:0]  CNT_WIN  = CW'(KERNEL_W);
  localparam logic [PW1-1:0] LEN_EXT  = PW1'(LINE_LEN);

  logic [DATA_W-1:0] mem [LINE_LEN];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] data_q;
  logic          valid_q;
  logic          line_end_q;

  logic          wr_ready;
  logic          rd_ready;
  logic          wr_acc;
  logic          rd_acc;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [WW-1:0] window;

  // Offsets never reach LINE_LEN, so one conditional subtract gives the modulo.
  function automatic logic [PW-1:0] tap_addr(input logic [PW-1:0] base, input int unsigned off);
    logic [PW1-1:0] sum;
    sum = {1'b0, base} + PW1'(off);
    if (sum >= LEN_EXT) sum = sum - LEN_EXT;
    return sum[PW-1:0];
  endfunction

  assign wr_ready = (count < CNT_MAX);
  assign rd_ready = (count >= CNT_WIN);

  // Reset wins over any request arriving on the same edge.
  assign wr_acc = bus.i_data_valid && wr_ready && !i_rst;
  assign rd_acc = bus.i_rd_data && rd_ready && !i_rst;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_acc) wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    if (rd_acc) rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Oldest pixel (at rd_ptr) lands in the most significant slot.
  always_comb begin
    window = '0;
    for (int k = 0; k < KERNEL_W; k++) begin
      window[(KERNEL_W - 1 - k) * DATA_W +: DATA_W] = mem[tap_addr(rd_ptr, k)];
    end
  end

  // Storage has no reset so it maps onto distributed RAM or plain registers.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      line_end_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      valid_q    <= rd_acc;
      line_end_q <= rd_acc && (rd_ptr == PTR_LAST);
      if (rd_acc) data_q <= window;
    end
  end

  assign bus.o_wr_ready   = wr_ready;
  assign bus.o_rd_ready   = rd_ready;
  assign bus.o_full       = (count == CNT_MAX);
  assign bus.o_empty      = (count == '0);
  assign bus.o_count      = count;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_line_end   = line_end_q;

`ifdef LINEBUF_ERR_STATS_EN
  logic        ovf_q;
  logic        udf_q;
  logic [15:0] drop_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (bus.i_data_valid && !wr_ready) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      if (bus.i_rd_data && !rd_ready) udf_q <= 1'b1;
    end
  end

  assign bus.o_ovf      = ovf_q;
  assign bus.o_udf      = udf_q;
  assign bus.o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_line_buffer_param.sv
// Directed bench for line_buffer_param at DATA_W=8, LINE_LEN=5, KERNEL_W=3.
// Statistics outputs are checked only when LINEBUF_ERR_STATS_EN is defined.
module tb_line_buffer_param;
  localparam int DATA_W   = 8;
  localparam int LINE_LEN = 5;
  localparam int KERNEL_W = 3;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  line_buffer_param_if #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .KERNEL_W(KERNEL_W)) bus ();

  line_buffer_param #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .KERNEL_W(KERNEL_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then advance one edge and settle past it.
  task automatic drive(input logic wv, input logic [7:0] wd, input logic rv);
    bus.i_data_valid = wv;
    bus.i_data       = wd;
    bus.i_rd_data    = rv;
    @(posedge i_clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [23:0] win, input logic [2:0] cnt, input logic le);
    chk({tag, "_valid"}, 64'(bus.o_data_valid), 64'd1);
    chk({tag, "_data"},  64'(bus.o_data), 64'(win));
    chk({tag, "_count"}, 64'(bus.o_count), 64'(cnt));
    chk({tag, "_le"},    64'(bus.o_line_end), 64'(le));
  endtask

  initial begin
    bus.i_data = '0; bus.i_data_valid = 1'b0; bus.i_rd_data = 1'b0;
    i_rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    i_rst = 1'b0;

    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_empty", 64'(bus.o_empty), 64'd1);
    chk("rst_full", 64'(bus.o_full), 64'd0);
    chk("rst_wr_ready", 64'(bus.o_wr_ready), 64'd1);
    chk("rst_rd_ready", 64'(bus.o_rd_ready), 64'd0);
    chk("rst_data", 64'(bus.o_data), 64'd0);
    chk("rst_valid", 64'(bus.o_data_valid), 64'd0);
    chk("rst_le", 64'(bus.o_line_end), 64'd0);

    // Fill the line.
    drive(1'b1, 8'h10, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    chk("w2_rd_ready", 64'(bus.o_rd_ready), 64'd0);
    drive(1'b1, 8'h12, 1'b0);
    chk("w3_count", 64'(bus.o_count), 64'd3);
    chk("w3_rd_ready", 64'(bus.o_rd_ready), 64'd1);
    chk("w3_empty", 64'(bus.o_empty), 64'd0);
    drive(1'b1, 8'h13, 1'b0);
    drive(1'b1, 8'h14, 1'b0);
    chk("w5_count", 64'(bus.o_count), 64'd5);
    chk("w5_full", 64'(bus.o_full), 64'd1);
    chk("w5_wr_ready", 64'(bus.o_wr_ready), 64'd0);

    // Three reads.
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("r1", 24'h101112, 3'd4, 1'b0);
    chk("r1_full", 64'(bus.o_full), 64'd0);
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("r2", 24'h111213, 3'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("r3", 24'h121314, 3'd2, 1'b0);
    chk("r3_rd_ready", 64'(bus.o_rd_ready), 64'd0);

    drive(1'b0, 8'h00, 1'b0);
    chk("idle_valid", 64'(bus.o_data_valid), 64'd0);
    chk("idle_hold", 64'(bus.o_data), 64'h121314);

    // Read while not ready is ignored.
    drive(1'b0, 8'h00, 1'b1);
    chk("udf_valid", 64'(bus.o_data_valid), 64'd0);
    chk("udf_count", 64'(bus.o_count), 64'd2);
    chk("udf_hold", 64'(bus.o_data), 64'h121314);

    // Wrap: write 0x15, 0x16 at indices 0 and 1.
    drive(1'b1, 8'h15, 1'b0);
    drive(1'b1, 8'h16, 1'b0);
    chk("wrap_count", 64'(bus.o_count), 64'd4);
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("wrap_r1", 24'h131415, 3'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("wrap_r2", 24'h141516, 3'd2, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("wrap_le_clear", 64'(bus.o_line_end), 64'd0);

    // Refill to full, then write 0xAA alongside a read.
    drive(1'b1, 8'h17, 1'b0);
    drive(1'b1, 8'h18, 1'b0);
    drive(1'b1, 8'h19, 1'b0);
    chk("refill_full", 64'(bus.o_full), 64'd1);
    drive(1'b1, 8'hAA, 1'b1);
    rd_chk("ovf_r", 24'h151617, 3'd4, 1'b0);
`ifdef LINEBUF_ERR_STATS_EN
    chk("ovf_flag", 64'(bus.o_ovf), 64'd1);
    chk("drop_cnt", 64'(bus.o_drop_cnt), 64'd1);
    chk("udf_flag", 64'(bus.o_udf), 64'd1);
`endif
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("post_ovf_r1", 24'h161718, 3'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("post_ovf_r2", 24'h171819, 3'd2, 1'b0);
    drive(1'b1, 8'h1A, 1'b0);
    drive(1'b1, 8'h1B, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    rd_chk("no_aa", 24'h18191A, 3'd3, 1'b0);

    // Streaming at count 3.
    drive(1'b1, 8'h20, 1'b1);
    rd_chk("s1", 24'h191A1B, 3'd3, 1'b1);
    drive(1'b1, 8'h21, 1'b1);
    rd_chk("s2", 24'h1A1B20, 3'd3, 1'b0);
    drive(1'b1, 8'h22, 1'b1);
    rd_chk("s3", 24'h1B2021, 3'd3, 1'b0);
    drive(1'b1, 8'h23, 1'b1);
    rd_chk("s4", 24'h202122, 3'd3, 1'b0);

    // Reset mid-line with requests pending.
    drive(1'b1, 8'h24, 1'b0);
    chk("pre_rst_count", 64'(bus.o_count), 64'd4);
    i_rst = 1'b1;
    drive(1'b1, 8'h25, 1'b1);
    i_rst = 1'b0;
    chk("mid_rst_count", 64'(bus.o_count), 64'd0);
    chk("mid_rst_empty", 64'(bus.o_empty), 64'd1);
    chk("mid_rst_data", 64'(bus.o_data), 64'd0);
    chk("mid_rst_valid", 64'(bus.o_data_valid), 64'd0);
    chk("mid_rst_le", 64'(bus.o_line_end), 64'd0);
`ifdef LINEBUF_ERR_STATS_EN
    chk("mid_rst_ovf", 64'(bus.o_ovf), 64'd0);
    chk("mid_rst_drop", 64'(bus.o_drop_cnt), 64'd0);
`endif
    drive(1'b0, 8'h00, 1'b1);
    chk("post_rst_rd_valid", 64'(bus.o_data_valid), 64'd0);
    chk("post_rst_rd_count", 64'(bus.o_count), 64'd0);
    chk("post_rst_rd_data", 64'(bus.o_data), 64'd0);
    drive(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
